// File: rtl/cs_encode_scheduler.sv
// Encode scheduler: gathers M data symbols into a buffer for an external encoder,
// then streams the K coded rows out one handshake at a time.
module cs_encode_scheduler #(
  parameter int K = 5,
  parameter int M = 3,
  parameter int L = 11,
  localparam int W  = L - 1,
  localparam int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [W-1:0]          in_data_i,
  input  logic                  flush_i,
  output logic [M-1:0][W-1:0]   enc_data_o,
  input  logic [K-1:0][W-1:0]   enc_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [W-1:0]          out_data_o,
  output logic [IW-1:0]         out_idx_o,
  output logic                  out_last_o,
  output logic [15:0]           gen_cnt_o
);

  localparam int MW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t          state, state_nxt;
  logic [MW-1:0]   wr_idx;
  logic            in_hs, out_hs, wr_full, out_end;

  assign in_hs   = in_valid_i && in_ready_o;
  assign out_hs  = out_valid_o && out_ready_i;
  assign wr_full = (wr_idx == MW'(M - 1));
  assign out_end = (out_idx_o == IW'(K - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= COLLECT;
    else         state <= state_nxt;
  end

  // A flush only closes a generation that already holds at least one symbol.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (in_hs && (wr_full || flush_i))            state_nxt = EMIT;
        else if (!in_hs && flush_i && wr_idx != '0)   state_nxt = EMIT;
      end
      EMIT: begin
        if (out_hs && out_end) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready_o  = (state == COLLECT);
    out_valid_o = (state == EMIT);
    out_last_o  = out_valid_o && out_end;
    out_data_o  = '0;
    for (int r = 0; r < K; r++) begin
      if (out_idx_o == IW'(r)) out_data_o = enc_data_i[r];
    end
  end

  // Buffer is zeroed at generation end, so slots skipped by a flush read as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_idx     <= '0;
      out_idx_o  <= '0;
      gen_cnt_o  <= '0;
      enc_data_o <= '0;
    end else begin
      if (state == COLLECT) begin
        if (in_hs) begin
          for (int i = 0; i < M; i++) begin
            if (wr_idx == MW'(i)) enc_data_o[i] <= in_data_i;
          end
          wr_idx <= (state_nxt == EMIT) ? '0 : wr_idx + MW'(1);
        end else if (state_nxt == EMIT) begin
          wr_idx <= '0;
        end
      end
      if (out_hs) begin
        if (out_end) begin
          out_idx_o  <= '0;
          gen_cnt_o  <= gen_cnt_o + 16'd1;
          enc_data_o <= '0;
        end else begin
          out_idx_o <= out_idx_o + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cs_encode_scheduler.sv
// Directed bench for cs_encode_scheduler; the encoder is modelled as
// enc_data_i[r] = enc_data_o[r mod M].
module tb_cs_encode_scheduler;

  localparam int K  = 5;
  localparam int M  = 3;
  localparam int W  = 10;
  localparam int IW = 3;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 flush;
  logic [M-1:0][W-1:0]  enc_out;
  logic [K-1:0][W-1:0]  enc_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic [15:0]          gen_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar r = 0; r < K; r++) begin : g_enc
    assign enc_in[r] = enc_out[r % M];
  end

  cs_encode_scheduler #(.K(K), .M(M), .L(W + 1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .flush_i     (flush),
    .enc_data_o  (enc_out),
    .enc_data_i  (enc_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .gen_cnt_o   (gen_cnt)
  );

  // Inputs change just after a falling edge; outputs are sampled there too.
  task automatic push(input logic [W-1:0] d, input logic fl);
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_last got=%b exp=0", out_last); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("[TB] FAIL rst_out_idx got=%0d exp=0", out_idx); end
    checks++; if (gen_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_gen_cnt got=%h exp=0", gen_cnt); end
    checks++; if (enc_out !== '0) begin errors++; $display("[TB] FAIL rst_enc_data got=%h exp=0", enc_out); end
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_d [5];
    exp_d = '{10'h001, 10'h002, 10'h003, 10'h001, 10'h002};
    out_ready = 1'b1;
    push(10'h001, 1'b0);
    push(10'h002, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got=%b exp=0", out_valid); end
    push(10'h003, 1'b0);
    for (int r = 0; r < K; r++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid r=%0d got v=%b rdy=%b exp v=1 rdy=0", r, out_valid, in_ready); end
      checks++; if (out_idx !== IW'(r)) begin errors++; $display("[TB] FAIL basic_idx got=%0d exp=%0d", out_idx, r); end
      checks++; if (out_data !== exp_d[r]) begin errors++; $display("[TB] FAIL basic_data r=%0d got=%h exp=%h", r, out_data, exp_d[r]); end
      checks++; if (out_last !== (r == K - 1)) begin errors++; $display("[TB] FAIL basic_last r=%0d got=%b", r, out_last); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_back_collect got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    checks++; if (gen_cnt !== 16'd1) begin errors++; $display("[TB] FAIL basic_gen_cnt got=%0d exp=1", gen_cnt); end
    checks++; if (enc_out !== '0) begin errors++; $display("[TB] FAIL basic_clear got=%h exp=0", enc_out); end
  endtask

  // Two generations with in_valid and out_ready held high: period M+K, no bubble.
  task automatic test_back_to_back();
    int p, g;
    logic [W-1:0] ed;
    out_ready = 1'b1;
    for (int c = 0; c < 2 * (M + K); c++) begin
      g = c / (M + K);
      p = c % (M + K);
      in_valid = 1'b1;
      in_data  = W'(10'h100 + c);
      checks++; if (in_ready !== (p < M) || out_valid !== (p >= M)) begin errors++; $display("[TB] FAIL b2b_phase c=%0d got rdy=%b v=%b", c, in_ready, out_valid); end
      if (p >= M) begin
        ed = W'(10'h100 + 8 * g + ((p - M) % M));
        checks++; if (out_idx !== IW'(p - M) || out_data !== ed) begin errors++; $display("[TB] FAIL b2b_data c=%0d got idx=%0d d=%h exp idx=%0d d=%h", c, out_idx, out_data, p - M, ed); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (gen_cnt !== 16'd3) begin errors++; $display("[TB] FAIL b2b_gen_cnt got=%0d exp=3", gen_cnt); end
  endtask

  task automatic test_flush();
    logic [W-1:0] exp_d [5];
    exp_d = '{10'h155, 10'h000, 10'h000, 10'h155, 10'h000};
    out_ready = 1'b1;
    push(10'h155, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_pre_valid got=%b exp=0", out_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (enc_out !== {10'h000, 10'h000, 10'h155}) begin errors++; $display("[TB] FAIL flush_buffer got=%h exp=%h", enc_out, {10'h000, 10'h000, 10'h155}); end
    for (int r = 0; r < K; r++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[r]) begin errors++; $display("[TB] FAIL flush_data r=%0d got v=%b d=%h exp d=%h", r, out_valid, out_data, exp_d[r]); end
      @(negedge clk);
    end
    checks++; if (gen_cnt !== 16'd4) begin errors++; $display("[TB] FAIL flush_gen_cnt got=%0d exp=4", gen_cnt); end
  endtask

  task automatic test_stall();
    logic [W-1:0] exp_d [5];
    exp_d = '{10'h0A1, 10'h0A2, 10'h0A3, 10'h0A1, 10'h0A2};
    out_ready = 1'b1;
    push(10'h0A1, 1'b0);
    push(10'h0A2, 1'b0);
    push(10'h0A3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1;
      in_data  = 10'h3FF;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ctrl s=%0d got v=%b rdy=%b exp v=1 rdy=0", s, out_valid, in_ready); end
      checks++; if (out_idx !== 3'd2 || out_data !== 10'h0A3) begin errors++; $display("[TB] FAIL stall_hold s=%0d got idx=%0d d=%h exp idx=2 d=0a3", s, out_idx, out_data); end
      checks++; if (enc_out !== {10'h0A3, 10'h0A2, 10'h0A1}) begin errors++; $display("[TB] FAIL stall_buffer s=%0d got=%h", s, enc_out); end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int r = 2; r < K; r++) begin
      checks++; if (out_idx !== IW'(r) || out_data !== exp_d[r]) begin errors++; $display("[TB] FAIL stall_resume r=%0d got idx=%0d d=%h exp d=%h", r, out_idx, out_data, exp_d[r]); end
      @(negedge clk);
    end
    checks++; if (gen_cnt !== 16'd5 || enc_out !== '0) begin errors++; $display("[TB] FAIL stall_end got gen=%0d enc=%h exp gen=5 enc=0", gen_cnt, enc_out); end
  endtask

  task automatic test_flush_edge();
    logic [W-1:0] exp_d [5];
    exp_d = '{10'h011, 10'h012, 10'h013, 10'h011, 10'h012};
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    push(10'h011, 1'b0);
    push(10'h012, 1'b0);
    push(10'h013, 1'b1);
    checks++; if (enc_out !== {10'h013, 10'h012, 10'h011}) begin errors++; $display("[TB] FAIL flush_full_buffer got=%h", enc_out); end
    for (int r = 0; r < K; r++) begin
      flush = (r < K - 1);
      checks++; if (out_valid !== 1'b1 || out_idx !== IW'(r) || out_data !== exp_d[r]) begin errors++; $display("[TB] FAIL flush_full_data r=%0d got v=%b idx=%0d d=%h exp d=%h", r, out_valid, out_idx, out_data, exp_d[r]); end
      @(negedge clk);
    end
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || gen_cnt !== 16'd6) begin errors++; $display("[TB] FAIL flush_full_end got rdy=%b gen=%0d exp rdy=1 gen=6", in_ready, gen_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_d [5];
    exp_d = '{10'h031, 10'h032, 10'h033, 10'h031, 10'h032};
    out_ready = 1'b1;
    push(10'h021, 1'b0);
    push(10'h022, 1'b0);
    push(10'h023, 1'b0);
    for (int r = 0; r < 3; r++) @(negedge clk);
    checks++; if (out_idx !== 3'd3) begin errors++; $display("[TB] FAIL mid_pre_idx got=%0d exp=3", out_idx); end
    rst_ni = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ctrl got rdy=%b v=%b last=%b", in_ready, out_valid, out_last); end
    checks++; if (out_idx !== 3'd0 || gen_cnt !== 16'd0 || enc_out !== '0) begin errors++; $display("[TB] FAIL mid_rst_state got idx=%0d gen=%0d enc=%h", out_idx, gen_cnt, enc_out); end
    @(negedge clk);
    rst_ni = 1'b1;
    push(10'h031, 1'b0);
    push(10'h032, 1'b0);
    push(10'h033, 1'b0);
    for (int r = 0; r < K; r++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[r]) begin errors++; $display("[TB] FAIL mid_data r=%0d got v=%b d=%h exp d=%h", r, out_valid, out_data, exp_d[r]); end
      @(negedge clk);
    end
    checks++; if (gen_cnt !== 16'd1) begin errors++; $display("[TB] FAIL mid_gen_cnt got=%0d exp=1", gen_cnt); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    force dut.gen_cnt_o = 16'hFFFF;
    @(negedge clk);
    release dut.gen_cnt_o;
    push(10'h041, 1'b0);
    push(10'h042, 1'b0);
    push(10'h043, 1'b0);
    for (int r = 0; r < K; r++) @(negedge clk);
    checks++; if (gen_cnt !== 16'h0000 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL wrap_gen_cnt got=%h rdy=%b exp=0000 rdy=1", gen_cnt, in_ready); end
  endtask

  initial begin
    rst_ni    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_stall();
    test_flush_edge();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
